// File: rtl/eth_measurer_pkg.sv
// rtl/eth_measurer_pkg.sv - shared types and defaults for the latency measurer control path
package eth_measurer_pkg;

   // Default width of the period, timeout and statistics counters
   localparam int CNT_W_DEF = 32;

   // Exchange sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_MAIN,
      ST_WAIT_LOOP_RX,
      ST_REQ_LOOP,
      ST_WAIT_MAIN_RX,
      ST_WAIT_PERIOD
   } ctrl_state_t;

endpackage

// File: rtl/eth_measurer_countdown.sv
// rtl/eth_measurer_countdown.sv - loadable down-counter that saturates at zero
module eth_measurer_countdown
   import eth_measurer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             expire
);

   // Load wins over counting; once drained the counter parks at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Last counted cycle of a window; a reload in the same cycle cancels it
   assign expire = (cnt == CNT_W'(1)) && !load;

endmodule

// File: rtl/eth_measurer_ctrl.sv
// rtl/eth_measurer_ctrl.sv - ping/pong exchange sequencer with timeouts and loss statistics
module eth_measurer_ctrl
   import eth_measurer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] timeout,
   output logic             main_tx_req,
   input  logic             main_tx_begin,
   input  logic             loop_rx_end,
   output logic             loop_tx_req,
   input  logic             loop_tx_begin,
   input  logic             main_rx_end,
   output logic             loop_rx_timeout,
   output logic             main_rx_timeout,
   output logic             busy,
   output logic [CNT_W-1:0] exchange_count,
   output logic [CNT_W-1:0] loss_count
);

   ctrl_state_t      state;
   ctrl_state_t      state_nx;

   logic [CNT_W-1:0] period_q;
   logic [CNT_W-1:0] timeout_q;
   logic [CNT_W-1:0] tcnt;
   logic [CNT_W-1:0] pcnt;

   logic             t_load;
   logic             p_load;
   logic             t_expire;
   logic             p_expire_unused;
   logic             p_zero;

   logic             latch_cfg;
   logic             loop_to;
   logic             main_to;
   logic             exc_inc;
   logic             loss_inc;

   // The leg timer restarts on every leg start event; the period timer only on the ping
   assign t_load = ((state == ST_REQ_MAIN)     && main_tx_begin) ||
                   ((state == ST_WAIT_LOOP_RX) && loop_rx_end)   ||
                   ((state == ST_REQ_LOOP)     && loop_tx_begin);
   assign p_load = (state == ST_REQ_MAIN) && main_tx_begin;
   assign p_zero = (pcnt == '0);

   eth_measurer_countdown #(
      .CNT_W    (CNT_W)
   ) u_tcnt (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (timeout_q),
      .cnt      (tcnt),
      .expire   (t_expire)
   );

   eth_measurer_countdown #(
      .CNT_W    (CNT_W)
   ) u_pcnt (
      .clk      (clk),
      .rst      (rst),
      .load     (p_load),
      .load_val (period_q),
      .cnt      (pcnt),
      .expire   (p_expire_unused)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and single-cycle decisions; a terminating event always beats expiry
   always_comb begin
      state_nx  = state;
      latch_cfg = 1'b0;
      loop_to   = 1'b0;
      main_to   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               latch_cfg = 1'b1;
               state_nx  = ST_REQ_MAIN;
            end
         end
         ST_REQ_MAIN: begin
            if (main_tx_begin) begin
               state_nx = ST_WAIT_LOOP_RX;
            end
         end
         ST_WAIT_LOOP_RX: begin
            if (loop_rx_end) begin
               state_nx = ST_REQ_LOOP;
            end else if (t_expire) begin
               loop_to  = 1'b1;
               state_nx = ST_WAIT_PERIOD;
            end
         end
         ST_REQ_LOOP: begin
            if (loop_tx_begin) begin
               state_nx = ST_WAIT_MAIN_RX;
            end else if (t_expire) begin
               main_to  = 1'b1;
               state_nx = ST_WAIT_PERIOD;
            end
         end
         ST_WAIT_MAIN_RX: begin
            if (main_rx_end) begin
               state_nx = ST_WAIT_PERIOD;
            end else if (t_expire) begin
               main_to  = 1'b1;
               state_nx = ST_WAIT_PERIOD;
            end
         end
         ST_WAIT_PERIOD: begin
            if (p_zero) begin
               if (enable) begin
                  latch_cfg = 1'b1;
                  state_nx  = ST_REQ_MAIN;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   assign exc_inc  = (state_nx == ST_WAIT_PERIOD) && (state != ST_WAIT_PERIOD);
   assign loss_inc = loop_to || main_to;

   // Configuration snapshot; a zero timeout is widened to one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q  <= '0;
         timeout_q <= '0;
      end else if (latch_cfg) begin
         period_q  <= period;
         timeout_q <= (timeout == '0) ? CNT_W'(1) : timeout;
      end
   end

   // Registered outputs; requests drop as soon as their state is left
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_tx_req     <= 1'b0;
         loop_tx_req     <= 1'b0;
         loop_rx_timeout <= 1'b0;
         main_rx_timeout <= 1'b0;
         busy            <= 1'b0;
      end else begin
         main_tx_req     <= (state == ST_REQ_MAIN) && (state_nx == ST_REQ_MAIN);
         loop_tx_req     <= (state == ST_REQ_LOOP) && (state_nx == ST_REQ_LOOP);
         loop_rx_timeout <= loop_to;
         main_rx_timeout <= main_to;
         busy            <= (state_nx != ST_IDLE);
      end
   end

   // Statistics counters stick at all-ones instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exchange_count <= '0;
         loss_count     <= '0;
      end else begin
         if (exc_inc && (exchange_count != '1)) begin
            exchange_count <= exchange_count + CNT_W'(1);
         end
         if (loss_inc && (loss_count != '1)) begin
            loss_count <= loss_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_eth_measurer_ctrl.sv
// tb/tb_eth_measurer_ctrl.sv - self-checking bench for the exchange sequencer
module tb_eth_measurer_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [W-1:0] period;
   logic [W-1:0] timeout;
   logic         main_tx_req;
   logic         main_tx_begin;
   logic         loop_rx_end;
   logic         loop_tx_req;
   logic         loop_tx_begin;
   logic         main_rx_end;
   logic         loop_rx_timeout;
   logic         main_rx_timeout;
   logic         busy;
   logic [W-1:0] exchange_count;
   logic [W-1:0] loss_count;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] exp_exc = '0;
   logic [W-1:0] exp_loss = '0;

   always #5 clk = ~clk;

   eth_measurer_ctrl #(.CNT_W(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .period          (period),
      .timeout         (timeout),
      .main_tx_req     (main_tx_req),
      .main_tx_begin   (main_tx_begin),
      .loop_rx_end     (loop_rx_end),
      .loop_tx_req     (loop_tx_req),
      .loop_tx_begin   (loop_tx_begin),
      .main_rx_end     (main_rx_end),
      .loop_rx_timeout (loop_rx_timeout),
      .main_rx_timeout (main_rx_timeout),
      .busy            (busy),
      .exchange_count  (exchange_count),
      .loss_count      (loss_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      main_tx_begin = 1'b0;
      loop_rx_end   = 1'b0;
      loop_tx_begin = 1'b0;
      main_rx_end   = 1'b0;
   endtask

   function automatic int pick_d(input int t);
      int r;
      r = int'($urandom_range(0, 5));
      if (r == 0) return 0;
      if (r == 1) return t;
      return int'($urandom_range(1, t));
   endfunction

   task automatic start_from_idle(input int t, input int p);
      period  = p;
      timeout = t;
      enable  = 1'b1;
      tick();
      chk("idle_start_busy", busy, 1);
      chk("idle_start_req", main_tx_req, 0);
      tick();
   endtask

   // One exchange. Called in the cycle main_tx_req must be high. d1/d2/d3 are the
   // delays of each terminating event after its leg start; outside 1..T means the frame is lost.
   task automatic exchange(input int t_cfg, input int p_cfg, input int d1, input int d2,
                           input int d3, input bit drop, input int new_t, input int new_p,
                           input bit noise);
      int t, s2, s3, e1, e2, e3, w, lrx_k, mrx_k, big_l, leg, drop_k, n;
      bit en_at_l, lost;
      logic [W-1:0] exc_after, loss_after;
      t = (t_cfg == 0) ? 1 : t_cfg;
      s2 = -1; s3 = -1; e2 = -1; e3 = -1; lrx_k = -1; mrx_k = -1;
      if (d1 >= 1 && d1 <= t) begin
         s2 = d1; e1 = d1;
      end else begin
         e1 = t; lrx_k = t + 1;
      end
      w = e1 + 1;
      if (s2 >= 0) begin
         if (d2 >= 1 && d2 <= t) begin
            s3 = s2 + d2; e2 = s3;
         end else begin
            e2 = s2 + t; mrx_k = e2 + 1;
         end
         w = e2 + 1;
      end
      if (s3 >= 0) begin
         if (d3 >= 1 && d3 <= t) begin
            e3 = s3 + d3;
         end else begin
            e3 = s3 + t; mrx_k = e3 + 1;
         end
         w = e3 + 1;
      end
      lost  = (lrx_k > 0) || (mrx_k > 0);
      big_l = (w > p_cfg + 1) ? w : p_cfg + 1;
      drop_k = -1;
      if (drop) drop_k = (s3 >= 0) ? s3 + 1 + int'($urandom_range(0, e3 - s3 - 1)) : 1;
      exc_after  = (exp_exc == '1) ? exp_exc : exp_exc + 1;
      loss_after = (!lost || exp_loss == '1) ? exp_loss : exp_loss + 1;
      en_at_l = 1'b1;

      n = int'($urandom_range(0, 3));
      chk("main_tx_req_rise", main_tx_req, 1);
      repeat (n) begin
         tick();
         chk("main_tx_req_hold", main_tx_req, 1);
      end
      main_tx_begin = 1'b1;
      period  = new_p;
      timeout = new_t;
      for (int k = 1; k <= big_l + 1; k++) begin
         tick();
         clear_events();
         if (k <= e1) leg = 1;
         else if (k <= e2) leg = 2;
         else if (k <= e3) leg = 3;
         else if (k <= big_l) leg = 4;
         else leg = 0;
         if (noise && leg != 0 && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: if (leg != 1) loop_rx_end = 1'b1;
               1: if (leg != 2) loop_tx_begin = 1'b1;
               2: if (leg != 3) main_rx_end = 1'b1;
               default: main_tx_begin = 1'b1;
            endcase
         end
         if (k == s2) loop_rx_end = 1'b1;
         if (k == s3) loop_tx_begin = 1'b1;
         if (s3 >= 0 && k == e3 && mrx_k < 0) main_rx_end = 1'b1;
         if (k == drop_k) enable = 1'b0;
         if (k == big_l) en_at_l = enable;
         chk("loop_rx_timeout", loop_rx_timeout, k == lrx_k);
         chk("main_rx_timeout", main_rx_timeout, k == mrx_k);
         chk("loop_tx_req", loop_tx_req, s2 >= 0 && k >= s2 + 2 && k <= e2);
         chk("main_tx_req_low", main_tx_req, 0);
         chk("busy", busy, (k <= big_l) ? 1'b1 : en_at_l);
         chk("exchange_count", exchange_count, (k >= w) ? exc_after : exp_exc);
         chk("loss_count", loss_count, (k >= w) ? loss_after : exp_loss);
      end
      tick();
      clear_events();
      exp_exc  = exc_after;
      exp_loss = loss_after;
   endtask

   initial begin
      int cur_t, cur_p, nt, np, te;
      rst = 1'b1;
      enable = 1'b0;
      period = '0;
      timeout = '0;
      clear_events();
      repeat (3) tick();
      chk("rst_main_tx_req", main_tx_req, 0);
      chk("rst_loop_tx_req", loop_tx_req, 0);
      chk("rst_loop_rx_timeout", loop_rx_timeout, 0);
      chk("rst_main_rx_timeout", main_rx_timeout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_exchange_count", exchange_count, 0);
      chk("rst_loss_count", loss_count, 0);
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // Normal exchange, lost ping, lost pong, race at expiry
      start_from_idle(100, 500);
      exchange(100, 500, 10, 10, 10, 1'b0, 100, 500, 1'b0);
      exchange(100, 500, 0, 0, 0, 1'b0, 100, 120, 1'b0);
      exchange(100, 120, 20, 5, 0, 1'b0, 100, 120, 1'b0);
      exchange(100, 120, 100, 7, 9, 1'b0, 0, 10, 1'b0);
      // Zero timeout behaves as one cycle
      exchange(0, 10, 1, 0, 0, 1'b0, 0, 10, 1'b0);
      exchange(0, 10, 0, 0, 0, 1'b0, 17, 40, 1'b0);
      cur_t = 17;
      cur_p = 40;

      // Random exchanges with stray events sprinkled in
      for (int i = 0; i < 30; i++) begin
         nt = int'($urandom_range(0, 40));
         np = int'($urandom_range(0, 80));
         te = (cur_t == 0) ? 1 : cur_t;
         exchange(cur_t, cur_p, pick_d(te), pick_d(te), pick_d(te), 1'b0, nt, np, 1'b1);
         cur_t = nt;
         cur_p = np;
      end

      // Enable dropped inside WAIT_MAIN_RX: exchange completes, then IDLE
      te = (cur_t == 0) ? 1 : cur_t;
      exchange(cur_t, cur_p, int'($urandom_range(1, te)), int'($urandom_range(1, te)),
               pick_d(te), 1'b1, 30, 30, 1'b1);
      repeat (4) begin
         chk("drop_idle_busy", busy, 0);
         chk("drop_idle_req", main_tx_req, 0);
         tick();
      end

      // Reset in WAIT_LOOP_RX aborts immediately with no timeout pulse
      start_from_idle(20, 60);
      chk("pre_abort_req", main_tx_req, 1);
      main_tx_begin = 1'b1;
      tick();
      main_tx_begin = 1'b0;
      repeat (5) tick();
      chk("pre_abort_busy", busy, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_main_tx_req", main_tx_req, 0);
      chk("abort_loop_tx_req", loop_tx_req, 0);
      chk("abort_loop_rx_timeout", loop_rx_timeout, 0);
      chk("abort_main_rx_timeout", main_rx_timeout, 0);
      chk("abort_busy", busy, 0);
      chk("abort_exchange_count", exchange_count, 0);
      chk("abort_loss_count", loss_count, 0);
      enable = 1'b0;
      tick();
      rst = 1'b0;
      exp_exc = '0;
      exp_loss = '0;
      repeat (30) begin
         tick();
         chk("post_abort_loop_rx_timeout", loop_rx_timeout, 0);
         chk("post_abort_busy", busy, 0);
         chk("post_abort_loss", loss_count, 0);
      end

      // Saturation: counters preloaded to all-ones stay there across a lossy exchange
      force dut.exchange_count = '1;
      force dut.loss_count = '1;
      tick();
      release dut.exchange_count;
      release dut.loss_count;
      tick();
      exp_exc = '1;
      exp_loss = '1;
      chk("sat_preload_exchange", exchange_count, exp_exc);
      chk("sat_preload_loss", loss_count, exp_loss);
      start_from_idle(15, 25);
      exchange(15, 25, 0, 0, 0, 1'b1, 15, 25, 1'b0);
      chk("sat_exchange_count", exchange_count, {W{1'b1}});
      chk("sat_loss_count", loss_count, {W{1'b1}});
      chk("sat_idle_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_measurer_ctrl.md
# eth_measurer_ctrl

Control sequencer for the Ethernet latency measurer. It sits directly upstream of the measurer timer and runs the ping/pong exchange cycle:
- requests a ping frame on the main port, then a pong frame on the loop port;
- enforces a per-leg timeout and the measurement period;
- generates the `main_rx_timeout` / `loop_rx_timeout` pulses that the timer consumes;
- keeps saturating exchange and loss counters for the register file.

## Interface
Parameters:
- `CNT_W`, 32: width of the period, timeout and statistics counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run measurements while high.
- `period` in CNT_W: minimum number of cycles between consecutive `main_tx_begin` events.
- `timeout` in CNT_W: maximum wait per leg in cycles; 0 is treated as 1.
- `main_tx_req` out 1: request for a ping frame on the main port; held until `main_tx_begin`.
- `main_tx_begin` in 1: one-cycle pulse, main MAC started the ping frame.
- `loop_rx_end` in 1: one-cycle pulse, ping fully received on the loop port.
- `loop_tx_req` out 1: request for a pong frame on the loop port; held until `loop_tx_begin`.
- `loop_tx_begin` in 1: one-cycle pulse, loop MAC started the pong frame.
- `main_rx_end` in 1: one-cycle pulse, pong fully received on the main port.
- `loop_rx_timeout` out 1: one-cycle pulse, ping was lost.
- `main_rx_timeout` out 1: one-cycle pulse, pong was lost or never sent.
- `busy` out 1: high in every state except IDLE.
- `exchange_count` out CNT_W: completed exchanges, whether successful or timed out.
- `loss_count` out CNT_W: exchanges that ended in either timeout.

## Operation
- State machine: IDLE, REQ_MAIN, WAIT_LOOP_RX, REQ_LOOP, WAIT_MAIN_RX, WAIT_PERIOD.
- IDLE: when `enable`=1, latch `period` and `timeout` (0 maps to 1), then go to REQ_MAIN. Config changes during an exchange take effect at the next latch.
- REQ_MAIN: `main_tx_req`=1.
  - On `main_tx_begin`, load `tcnt` with the timeout value and `pcnt` with the period value.
  - Go to WAIT_LOOP_RX.
- WAIT_LOOP_RX: `tcnt` decrements every cycle.
  - `loop_rx_end` → go to REQ_LOOP and reload `tcnt`.
  - Otherwise, when `tcnt`=1 → pulse `loop_rx_timeout`, increment `loss_count`, go to WAIT_PERIOD.
- REQ_LOOP: `loop_tx_req`=1 and `tcnt` keeps decrementing.
  - `loop_tx_begin` → reload `tcnt`, go to WAIT_MAIN_RX.
  - Expiry → pulse `main_rx_timeout`, increment `loss_count`, go to WAIT_PERIOD.
- WAIT_MAIN_RX:
  - `main_rx_end` → go to WAIT_PERIOD.
  - Expiry → pulse `main_rx_timeout`, increment `loss_count`, go to WAIT_PERIOD.
- `exchange_count` increments on every entry to WAIT_PERIOD.
- WAIT_PERIOD: stay until `pcnt`=0.
  - `pcnt` decrements every cycle from the cycle after `main_tx_begin` and saturates at 0.
  - Then: `enable`=1 → relatch config, go to REQ_MAIN; otherwise go to IDLE.
- Deasserting `enable` mid-exchange does not abort the exchange; the block returns to IDLE after WAIT_PERIOD.
- Events arriving in a state that does not expect them are ignored: no counter change, no output.
- If a terminating event (`loop_rx_end`, `loop_tx_begin`, `main_rx_end`) arrives in the same cycle the timeout expires, the event wins and no timeout pulse is generated.
- Statistics counters saturate at all-ones; they never wrap.

## Timing
- Reset values: all outputs 0, state IDLE, `tcnt`/`pcnt`/counters 0. A reset mid-exchange aborts it immediately, with no timeout pulse.
- All outputs are registered.
- `main_tx_req` rises 1 cycle after entering REQ_MAIN and falls the cycle after `main_tx_begin`. `loop_tx_req` behaves the same way against `loop_tx_begin`.
- Timeout window: leg start event in cycle 0 (`main_tx_begin` for WAIT_LOOP_RX; `loop_rx_end` or `loop_tx_begin` for the later legs).
  - Terminating events are accepted in cycles 1..T.
  - With no event, the timeout pulse is high in cycle T+1, lasting exactly 1 cycle.
- Timeout pulses and counter updates appear in the same cycle.
- Start-to-start spacing between consecutive `main_tx_begin` events is at least max(`period`, exchange duration + 2) cycles.
- `busy` is registered from the state and falls in the first cycle of IDLE.

## Structure
- Shared package `eth_measurer_pkg`: state enum `ctrl_state_t` and the constant `CNT_W` default.
- Sub-module `eth_measurer_countdown`: loadable CNT_W down-counter with saturation at 0 and an `expire` flag (`cnt`==1 with no load). Instantiate it twice, once for `tcnt` and once for `pcnt`.
- Connect the timeout outputs directly to the measurer timer; there is no extra pipeline stage between the two blocks.

## Test plan
- Normal exchange: `timeout`=100, `period`=500, events 10 cycles apart. Required: no timeout pulses, `exchange_count`=1, `loss_count`=0, next `main_tx_req` rises after 500 cycles.
- Lost ping: `timeout`=100, no `loop_rx_end`. Required: `loop_rx_timeout` high exactly in cycle 101 after `main_tx_begin`, `loss_count`=1, `loop_tx_req` never asserted.
- Lost pong: `loop_rx_end` at cycle 20, `loop_tx_begin` at cycle 25, no `main_rx_end`. Required: `main_rx_timeout` in cycle 126, `loop_rx_timeout` never asserted.
- Race: `loop_rx_end` in the same cycle the timeout expires (cycle 100, `timeout`=100). Required: no timeout pulse, transition to REQ_LOOP.
- Control and boundaries:
  - `enable` dropped during WAIT_MAIN_RX: exchange completes, then IDLE with `busy`=0.
  - `timeout`=0: behaves as 1.
  - `rst` pulsed in WAIT_LOOP_RX: all outputs 0 in the same cycle.
- Saturation: preload counters to all-ones via force, then run one lossy exchange. Required: both counters remain all-ones.
